// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the shift-accumulate datapath.
//   - DEF_DATA_W / DEF_SHAMT_W / DEF_ACC_W / DEF_LEN_W : default widths
//   - state_e : job-control states of shift_accumulate_unit
// Optional feature macro used by the datapath: SHIFT_ACC_SATURATE_EN
// -----------------------------------------------------------------------------
package accel_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_SHAMT_W = 4;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_LEN_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_left_stage.sv
// -----------------------------------------------------------------------------
// shift_left_stage
// Stage 1 of the accumulate pipeline: registers (in_data << in_shamt)
// truncated to DATA_W bits, tracks whether the register holds a live element,
// and presents the value sign-extended to ACC_W.
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        synchronous reset, active-low
//   load       in   1        capture a new operand pair this cycle
//   in_data    in   DATA_W   operand
//   in_shamt   in   SHAMT_W  shift amount
//   pipe_valid out  1        register holds an element not yet accumulated
//   shifted    out  ACC_W    registered shift result, sign-extended
// -----------------------------------------------------------------------------
module shift_left_stage
    import accel_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               pipe_valid,
    output logic [ACC_W-1:0]   shifted
);

    logic [DATA_W-1:0] shift_r;
    logic              valid_r;

    // The shifted value is two's complement at DATA_W; widen it to ACC_W.
    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    // Shift register and its valid flag; bits shifted past DATA_W are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= load;
            if (load) begin
                shift_r <= in_data << in_shamt;
            end
        end
    end

    assign pipe_valid = valid_r;
    assign shifted    = sext(shift_r);

endmodule

// File: rtl/shift_accumulate_unit.sv
// -----------------------------------------------------------------------------
// shift_accumulate_unit
// Accepts LEN (operand, shift) pairs, left-shifts each in a registered stage,
// sign-extends and sums them, then offers the sum via a valid/ready handshake.
// Ports:
//   clk        in   1        clock
//   rst_n      in   1        synchronous reset, active-low (abandons any job)
//   start      in   1        begin a job (only honoured in IDLE)
//   len        in   LEN_W    element count, sampled with start
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        unit accepts an operand pair
//   in_data    in   DATA_W   operand
//   in_shamt   in   SHAMT_W  shift amount
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream takes the result
//   out_data   out  ACC_W    accumulated sum
//   busy       out  1        any state other than IDLE
//   ovf        out  1        sticky saturation flag for the current job
// Build option: SHIFT_ACC_SATURATE_EN defined -> each add clamps to the signed
// ACC_W range and sets ovf; undefined -> adds wrap and ovf stays 0.
// -----------------------------------------------------------------------------
module shift_accumulate_unit
    import accel_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data,
    output logic               busy,
    output logic               ovf
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e             state_r,     state_nxt_s;
    logic [LEN_W-1:0]   count_r,     count_nxt_s;
    logic [ACC_W-1:0]   acc_r,       acc_nxt_s;
    logic               ovf_r,       ovf_nxt_s;
    logic [ACC_W-1:0]   out_data_r,  out_data_nxt_s;
    logic               in_ready_r,  in_ready_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic               busy_r,      busy_nxt_s;

    logic               xfer_s;
    logic               pipe_valid_s;
    logic [ACC_W-1:0]   shifted_s;
    logic [ACC_W-1:0]   add_res_s;
    logic               clamp_s;

    // in_ready is registered, so a transfer is judged against the value the
    // upstream sees during this cycle.
    assign xfer_s = in_valid & in_ready_r;

    shift_left_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W),
        .ACC_W   (ACC_W)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (xfer_s),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .pipe_valid (pipe_valid_s),
        .shifted    (shifted_s)
    );

`ifdef SHIFT_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide_s;

    // One guard bit exposes signed overflow; clamp toward the sign of the
    // true (unbounded) sum, which is the guard bit.
    always_comb begin
        sum_wide_s = {acc_r[ACC_W-1], acc_r} + {shifted_s[ACC_W-1], shifted_s};
        if (sum_wide_s[ACC_W] != sum_wide_s[ACC_W-1]) begin
            clamp_s = 1'b1;
            if (sum_wide_s[ACC_W]) begin
                add_res_s = ACC_MIN;
            end else begin
                add_res_s = ACC_MAX;
            end
        end else begin
            clamp_s   = 1'b0;
            add_res_s = sum_wide_s[ACC_W-1:0];
        end
    end
`else
    // Plain modulo-2^ACC_W accumulation; nothing ever clamps.
    always_comb begin
        add_res_s = acc_r + shifted_s;
        clamp_s   = 1'b0;
    end
`endif

    // Next-state, counter, accumulator and next-output computation.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        acc_nxt_s      = acc_r;
        ovf_nxt_s      = ovf_r;
        out_data_nxt_s = out_data_r;

        // Stage 2: fold the previous cycle's shifted element into the sum.
        if (pipe_valid_s) begin
            acc_nxt_s = add_res_s;
            ovf_nxt_s = ovf_r | clamp_s;
        end else begin
            acc_nxt_s = acc_r;
            ovf_nxt_s = ovf_r;
        end

        case (state_r)
            IDLE: begin
                if (start) begin
                    acc_nxt_s = '0;
                    ovf_nxt_s = 1'b0;
                    if (len != '0) begin
                        state_nxt_s = ACCUM;
                        count_nxt_s = len;
                    end else begin
                        state_nxt_s    = DONE;
                        out_data_nxt_s = '0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (count_r == '0) begin
                    state_nxt_s = DRAIN;
                end else if (xfer_s) begin
                    count_nxt_s = count_r - LEN_ONE;
                    if (count_r == LEN_ONE) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = ACCUM;
                    end
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DRAIN: begin
                // Once stage 1 is empty, acc_r already includes the last element.
                if (!pipe_valid_s) begin
                    state_nxt_s    = DONE;
                    out_data_nxt_s = acc_r;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        in_ready_nxt_s  = (state_nxt_s == ACCUM) && (count_nxt_s != '0);
        out_valid_nxt_s = (state_nxt_s == DONE);
        busy_nxt_s      = (state_nxt_s != IDLE);
    end

    // State and datapath registers, including the registered output flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= '0;
            acc_r       <= '0;
            ovf_r       <= 1'b0;
            out_data_r  <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            acc_r       <= acc_nxt_s;
            ovf_r       <= ovf_nxt_s;
            out_data_r  <= out_data_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_shift_accumulate_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_accumulate_unit
// Directed bench for shift_accumulate_unit built with ACC_W=20 so that the
// saturation/wrap boundary is reachable. A job-level model computes each
// expected sum from the element list; a compare process checks every cycle
// the result is offered. Honours SHIFT_ACC_SATURATE_EN like the design.
// -----------------------------------------------------------------------------
module tb_shift_accumulate_unit;

    localparam int DW = 16;
    localparam int SW = 4;
    localparam int AW = 20;
    localparam int LW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          busy;
    logic          ovf;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] va[$];
    logic [SW-1:0] vb[$];
    longint        exp_q[$];
    bit            exp_ovf_q[$];

    shift_accumulate_unit #(
        .DATA_W  (DW),
        .SHAMT_W (SW),
        .ACC_W   (AW),
        .LEN_W   (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Job model: plain signed arithmetic over the element list.
    task automatic model_push();
        longint acc = 0;
        bit     o   = 1'b0;
        longint mx  = (longint'(1) << (AW - 1)) - 1;
        longint mn  = -(longint'(1) << (AW - 1));
        for (int i = 0; i < va.size(); i++) begin
            logic [DW-1:0] t;
            logic [AW-1:0] w;
            t   = va[i] << vb[i];
            acc = acc + longint'($signed(t));
`ifdef SHIFT_ACC_SATURATE_EN
            if (acc > mx) begin acc = mx; o = 1'b1; end
            if (acc < mn) begin acc = mn; o = 1'b1; end
`else
            w   = acc[AW-1:0];
            acc = longint'($signed(w));
`endif
        end
        exp_q.push_back(acc);
        exp_ovf_q.push_back(o);
    endtask

    // Compare process: whenever a result is offered it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 1, 0);
            end else begin
                check("cmp_out_data", longint'($signed(out_data)), exp_q[0]);
                check("cmp_ovf", longint'(ovf), longint'(exp_ovf_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_ovf_q.pop_front());
                end
            end
        end
    end

    task automatic start_job(input int n);
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [SW-1:0] b);
        int w = 0;
        in_valid = 1'b1;
        in_data  = a;
        in_shamt = b;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) check("in_ready_timeout", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_timeout", longint'(out_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [AW-1:0] held;

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; in_shamt = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  longint'(in_ready),  0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy",      longint'(busy),      0);
        check("rst_ovf",       longint'(ovf),       0);
        check("rst_out_data",  longint'(out_data),  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: three back-to-back pairs, 2 + 12 + 5 = 19, result 2 cycles later
        va = '{16'd1, 16'd3, 16'd5}; vb = '{4'd1, 4'd2, 4'd0};
        model_push();
        start_job(3);
        check("t1_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 3; i++) send(va[i], vb[i]);
        wait_valid(cyc);
        check("t1_latency", cyc, 2);
        check("t1_sum", longint'($signed(out_data)), 19);
        check("t1_ovf", longint'(ovf), 0);
        @(posedge clk); #1;
        check("t1_idle_busy", longint'(busy), 0);

        // 2: 1 << 15 becomes 0x8000, negative after sign extension
        va = '{16'd1}; vb = '{4'd15};
        model_push();
        start_job(1);
        send(va[0], vb[0]);
        wait_valid(cyc);
        check("t2_signed", longint'($signed(out_data)), -32768);
        check("t2_raw", longint'(out_data), 20'hF8000);
        @(posedge clk); #1;

        // 3: empty job finishes immediately with zero
        va.delete(); vb.delete();
        model_push();
        start_job(0);
        check("t3_out_valid", longint'(out_valid), 1);
        check("t3_in_ready", longint'(in_ready), 0);
        check("t3_out_data", longint'(out_data), 0);
        @(posedge clk); #1;
        check("t3_idle", longint'(busy), 0);

        // 4: gapped input, start pulses while busy, back-pressured result
        va = '{16'd7, 16'hFFFF, 16'h0101, 16'd3}; vb = '{4'd3, 4'd0, 4'd8, 4'd14};
        model_push();
        out_ready = 1'b0;
        start_job(4);
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_valid(cyc);
        held = out_data;
        check("t4_sum", longint'($signed(out_data)), -16073);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("t4_hold_valid", longint'(out_valid), 1);
            check("t4_hold_data", longint'(out_data), longint'(held));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_idle", longint'(busy), 0);

        // 5: 17 x 32767 crosses the 20-bit signed limit
        va.delete(); vb.delete();
        for (int i = 0; i < 17; i++) begin va.push_back(16'd32767); vb.push_back(4'd0); end
        model_push();
        start_job(17);
        for (int i = 0; i < 17; i++) send(va[i], vb[i]);
        wait_valid(cyc);
`ifdef SHIFT_ACC_SATURATE_EN
        check("t5_sat", longint'($signed(out_data)), 524287);
        check("t5_ovf", longint'(ovf), 1);
`else
        check("t5_wrap", longint'($signed(out_data)), -491537);
        check("t5_ovf", longint'(ovf), 0);
`endif
        @(posedge clk); #1;

        // 6: reset mid-job (count=2) drops the job; a fresh job then works
        start_job(4);
        send(16'd9, 4'd0);
        send(16'd9, 4'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t6_in_ready",  longint'(in_ready),  0);
        check("t6_out_valid", longint'(out_valid), 0);
        check("t6_busy",      longint'(busy),      0);
        check("t6_ovf",       longint'(ovf),       0);
        check("t6_out_data",  longint'(out_data),  0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_result", longint'(out_valid), 0);
        va = '{16'd2, 16'd2}; vb = '{4'd1, 4'd1};
        model_push();
        start_job(2);
        for (int i = 0; i < 2; i++) send(va[i], vb[i]);
        wait_valid(cyc);
        check("t6_sum", longint'($signed(out_data)), 8);
        repeat (3) @(posedge clk);
        #1;
        check("all_results_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
